pulse_period_meter: RTL
=======================

// Module: pulse_period_meter
// PURPOSE
//  Receive-side counterpart to the game's tick generators. Measures the clk-cycle interval
//  between rising edges of a pulse/tick input (frame tick, game-step tick, external strobe).
//  Reports each interval with a one-cycle valid strobe, tracks min/max/count statistics and
//  flags loss of ticks via timeout. Used for rate verification and a debug readout.
// PARAMETERS
//  W        24           width of period, min_period, max_period and internal counter
//  TIMEOUT  24'd4000000  interval (cycles) after which ticks are declared lost; 2..2^W-1
//  SYNC_EN  1            1: pulse_in via 2-flop synchroniser (+2 cycles latency); 0: direct
//  CW       16           width of pulse_count
// PORTS
//  clk          in   1   system clock
//  reset_n      in   1   reset, synchronous, active-low
//  clear        in   1   sync clear: back to IDLE, statistics reset
//  pulse_in     in   1   measured pulse/tick
//  period       out  W   last measured interval, in clk cycles
//  period_valid out  1   one-cycle strobe: period/min/max/pulse_count just updated
//  timeout      out  1   high while in TIMEOUT state
//  min_period   out  W   smallest interval since reset/clear
//  max_period   out  W   largest interval since reset/clear
//  pulse_count  out  CW  number of valid intervals, saturating at 2^CW-1
// BEHAVIOUR
//  - Reset (reset_n=0 at posedge clk) and clear: state=IDLE, count=0, period=0,
//    period_valid=0, timeout=0, min_period=all ones, max_period=0, pulse_count=0.
//    Priority: reset_n > clear > edge > timeout.
//  - s = pulse_in (SYNC_EN=0) or 2-flop-synchronised pulse_in; s_d = s delayed one cycle
//    (s_d reset to 0). edge = s & ~s_d. Level held high yields exactly one edge.
//  - FSM states IDLE, MEASURE, TIMEOUT:
//    IDLE: on edge -> MEASURE, count<=1; no period_valid (first edge only arms).
//    MEASURE: count<=count+1 each cycle. On edge: period<=count, period_valid<=1 (next cycle),
//      count<=1, stay MEASURE. Edge in cycle k then next edge in cycle k+P => period=P.
//      If count==TIMEOUT and no edge -> TIMEOUT, timeout<=1, count held, period unchanged.
//      Edge in the same cycle that count==TIMEOUT: edge wins, period=TIMEOUT reported.
//    TIMEOUT: count frozen; on edge -> MEASURE, count<=1, timeout<=0, NO period_valid
//      (interval spanning a timeout is discarded).
//  - count never exceeds TIMEOUT; no wrap possible. Min interval measurable: 2 cycles.
//  - On each period_valid: min_period<=min(min_period,P), max_period<=max(max_period,P),
//    pulse_count<=pulse_count+1 unless all ones. All updated same cycle as period.
//  - period_valid is low in every cycle not directly following a measured edge.
//  - Latency: edge on pulse_in to period_valid = 1 cycle (SYNC_EN=0), 3 cycles (SYNC_EN=1).
//  - reset_n/clear mid-measurement: current partial interval discarded; next edge re-arms.
// TESTING
//  1 SYNC_EN=0, 1-cycle pulses every 5 cycles, 4 pulses -> 3 strobes, period=5,
//    min=max=5, pulse_count=3; no strobe for first pulse.
//  2 Intervals 7,3,12 -> period sequence 7,3,12; min_period=3, max_period=12, count=3.
//  3 TIMEOUT=20: pulse then silence -> timeout=1 exactly 20 cycles after arm edge, period
//    unchanged; next pulse -> timeout=0, no strobe; following pulse 6 later -> period=6.
//  4 TIMEOUT=20, second edge exactly at count==20 -> period=20, period_valid=1, timeout=0.
//  5 clear asserted mid-interval, same cycle as edge -> IDLE, stats reset, no strobe;
//    reset_n low mid-run -> all outputs at reset values next cycle.
//  6 SYNC_EN=1, pulse_in held high 10 cycles then low, repeat every 30 -> period=30,
//    strobe 3 cycles after each rising edge; CW=2 -> pulse_count saturates at 3.

Source files
------------

// File: rtl/pulse_period_meter.sv
// Measures clk-cycle spacing of pulse_in rising edges with min/max/count stats and tick-loss timeout.
// Latency edge->period_valid: 1 cycle (SYNC_EN=0) or 3 cycles (SYNC_EN=1); no backpressure, strobe is fire-and-forget.
module pulse_period_meter #(
    parameter int unsigned  W       = 24,
    parameter logic [W-1:0] TIMEOUT = 24'd4000000,
    parameter bit           SYNC_EN = 1'b1,
    parameter int unsigned  CW      = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic          pulse_in,
    output logic [W-1:0]  period,
    output logic          period_valid,
    output logic          timeout,
    output logic [W-1:0]  min_period,
    output logic [W-1:0]  max_period,
    output logic [CW-1:0] pulse_count
);

    typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_TIMEOUT} state_t;

    state_t         state;
    state_t         state_nxt;
    logic           s;
    logic           s_d;
    logic           rise;
    logic           meas_done;
    logic [W-1:0]   count;

    if (SYNC_EN) begin : g_sync
        logic [1:0] sync_q;
        always_ff @(posedge clk) begin
            if (!reset_n) sync_q <= 2'b00;
            else          sync_q <= {sync_q[0], pulse_in};
        end
        assign s = sync_q[1];
    end else begin : g_nosync
        assign s = pulse_in;
    end

    // s_d follows s through clear so a level held across clear cannot fake an edge
    always_ff @(posedge clk) begin
        if (!reset_n) s_d <= 1'b0;
        else          s_d <= s;
    end

    assign rise = s & ~s_d;

    always_ff @(posedge clk) begin
        if (!reset_n)   state <= S_IDLE;
        else if (clear) state <= S_IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:    if (rise) state_nxt = S_MEASURE;
            S_MEASURE: if (!rise && count == TIMEOUT) state_nxt = S_TIMEOUT;
            S_TIMEOUT: if (rise) state_nxt = S_MEASURE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        timeout   = (state == S_TIMEOUT);
        meas_done = (state == S_MEASURE) && rise;
    end

    // An edge always restarts the interval; only an edge seen while measuring closes one
    always_ff @(posedge clk) begin
        if (!reset_n || clear) begin
            count        <= '0;
            period       <= '0;
            period_valid <= 1'b0;
            min_period   <= '1;
            max_period   <= '0;
            pulse_count  <= '0;
        end else begin
            period_valid <= meas_done;
            if (rise)
                count <= W'(1);
            else if (state == S_MEASURE && count != TIMEOUT)
                count <= count + W'(1);
            if (meas_done) begin
                period <= count;
                if (count < min_period) min_period <= count;
                if (count > max_period) max_period <= count;
                if (pulse_count != '1)  pulse_count <= pulse_count + CW'(1);
            end
        end
    end

endmodule
